// File: rtl/ifu_inst_issue.sv
// Fetch-side issue stage: queues I-cache packets and issues up to two in-order
// instructions per cycle. Optional macro IFU_CROSS_PKT_PAIR_EN pairs i1 across packets.
module ifu_inst_issue #(
  parameter int unsigned PC_W      = 64,
  parameter int unsigned INST_W    = 32,
  parameter int unsigned PKT_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_flush,
  input  logic                ic_pkt_valid,
  output logic                ic_pkt_ready,
  input  logic [PC_W-1:0]     ic_pkt_pc,
  input  logic [4*INST_W-1:0] ic_pkt_data,
  input  logic [1:0]          ic_pkt_start,
  input  logic [1:0]          ic_pkt_end,
  input  logic                deu_ib2_val,
  input  logic                deu_ib3_val,
  output logic                ifu_i0_valid,
  output logic [PC_W-1:0]     ifu_i0_pc,
  output logic [INST_W-1:0]   ifu_i0_inst,
  output logic                ifu_i1_valid,
  output logic [PC_W-1:0]     ifu_i1_pc,
  output logic [INST_W-1:0]   ifu_i1_inst
);

  localparam int unsigned PtrW = $clog2(PKT_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PC_W-1:0]     pc_q   [PKT_DEPTH];
  logic [4*INST_W-1:0] data_q [PKT_DEPTH];
  logic [1:0]          slot_q [PKT_DEPTH];
  logic [1:0]          end_q  [PKT_DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]     count_q;

  logic                push;
  logic [1:0]          budget;
  logic                head_valid;
  logic [1:0]          head_slot, head_end, head_slot_new;
  logic                can0, can1_head, can1_cross;
  logic                pop_head, pop_next;
  logic [1:0]          num_pop;
  logic [1:0]          i1_slot;
  logic [PC_W-1:0]     i1_base;
  logic [4*INST_W-1:0] i1_data;

`ifdef IFU_CROSS_PKT_PAIR_EN
  logic [PtrW-1:0] nxt_ptr;
  assign nxt_ptr = rd_ptr_q + PtrW'(1);
`endif

  assign ic_pkt_ready = count_q < CntW'(PKT_DEPTH);
  // Inverted-range packets are consumed from the cache but never stored.
  assign push = ic_pkt_valid & ic_pkt_ready & ~ifu_flush & (ic_pkt_start <= ic_pkt_end);

  assign head_valid = count_q != '0;
  assign head_slot  = slot_q[rd_ptr_q];
  assign head_end   = end_q[rd_ptr_q];

  always_comb begin
    budget = 2'd2;
    if (deu_ib3_val)      budget = 2'd0;
    else if (deu_ib2_val) budget = 2'd1;
  end

  assign can0      = head_valid & (budget != 2'd0) & ~ifu_flush;
  assign can1_head = can0 & (budget == 2'd2) & (head_slot < head_end);
`ifdef IFU_CROSS_PKT_PAIR_EN
  assign can1_cross = can0 & (budget == 2'd2) & (head_slot == head_end) &
                      (count_q >= CntW'(2));
`else
  assign can1_cross = 1'b0;
`endif

  always_comb begin
    i1_slot = 2'(head_slot + 2'd1);
    i1_base = pc_q[rd_ptr_q];
    i1_data = data_q[rd_ptr_q];
`ifdef IFU_CROSS_PKT_PAIR_EN
    if (can1_cross) begin
      i1_slot = slot_q[nxt_ptr];
      i1_base = pc_q[nxt_ptr];
      i1_data = data_q[nxt_ptr];
    end
`endif
  end

  always_comb begin
    ifu_i0_valid = can0;
    ifu_i0_pc    = '0;
    ifu_i0_inst  = '0;
    ifu_i1_valid = can1_head | can1_cross;
    ifu_i1_pc    = '0;
    ifu_i1_inst  = '0;
    if (ifu_i0_valid) begin
      ifu_i0_pc   = pc_q[rd_ptr_q] + PC_W'({head_slot, 2'b00});
      ifu_i0_inst = data_q[rd_ptr_q][int'(head_slot)*INST_W +: INST_W];
    end
    if (ifu_i1_valid) begin
      ifu_i1_pc   = i1_base + PC_W'({i1_slot, 2'b00});
      ifu_i1_inst = i1_data[int'(i1_slot)*INST_W +: INST_W];
    end
  end

  always_comb begin
    head_slot_new = head_slot;
    pop_head      = 1'b0;
    pop_next      = 1'b0;
    if (can1_head) begin
      head_slot_new = 2'(head_slot + 2'd2);
      pop_head      = 2'(head_slot + 2'd1) == head_end;
    end else if (can0) begin
      head_slot_new = 2'(head_slot + 2'd1);
      pop_head      = head_slot == head_end;
    end
`ifdef IFU_CROSS_PKT_PAIR_EN
    if (can1_cross) pop_next = slot_q[nxt_ptr] == end_q[nxt_ptr];
`endif
    num_pop = {1'b0, pop_head} + {1'b0, pop_next};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(PKT_DEPTH); i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
        slot_q[i] <= '0;
        end_q[i]  <= '0;
      end
    end else if (ifu_flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // wr_ptr never aliases a live head/next entry, so these writes cannot collide.
      if (push) begin
        pc_q[wr_ptr_q]   <= ic_pkt_pc;
        data_q[wr_ptr_q] <= ic_pkt_data;
        slot_q[wr_ptr_q] <= ic_pkt_start;
        end_q[wr_ptr_q]  <= ic_pkt_end;
      end
      if (can0) slot_q[rd_ptr_q] <= head_slot_new;
`ifdef IFU_CROSS_PKT_PAIR_EN
      if (can1_cross) slot_q[nxt_ptr] <= 2'(slot_q[nxt_ptr] + 2'd1);
`endif
      rd_ptr_q <= rd_ptr_q + PtrW'(num_pop);
      wr_ptr_q <= wr_ptr_q + PtrW'(push);
      count_q  <= count_q + CntW'(push) - CntW'(num_pop);
    end
  end

endmodule

// File: tb/tb_ifu_inst_issue.sv
// Directed self-checking bench for ifu_inst_issue; follows IFU_CROSS_PKT_PAIR_EN
// when defined to select the cross-packet expectations.
module tb_ifu_inst_issue;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ifu_flush;
  logic         ic_pkt_valid;
  logic         ic_pkt_ready;
  logic [63:0]  ic_pkt_pc;
  logic [127:0] ic_pkt_data;
  logic [1:0]   ic_pkt_start;
  logic [1:0]   ic_pkt_end;
  logic         deu_ib2_val;
  logic         deu_ib3_val;
  logic         ifu_i0_valid;
  logic [63:0]  ifu_i0_pc;
  logic [31:0]  ifu_i0_inst;
  logic         ifu_i1_valid;
  logic [63:0]  ifu_i1_pc;
  logic [31:0]  ifu_i1_inst;

  int tests = 0;
  int fails = 0;

  ifu_inst_issue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_flush    (ifu_flush),
    .ic_pkt_valid (ic_pkt_valid),
    .ic_pkt_ready (ic_pkt_ready),
    .ic_pkt_pc    (ic_pkt_pc),
    .ic_pkt_data  (ic_pkt_data),
    .ic_pkt_start (ic_pkt_start),
    .ic_pkt_end   (ic_pkt_end),
    .deu_ib2_val  (deu_ib2_val),
    .deu_ib3_val  (deu_ib3_val),
    .ifu_i0_valid (ifu_i0_valid),
    .ifu_i0_pc    (ifu_i0_pc),
    .ifu_i0_inst  (ifu_i0_inst),
    .ifu_i1_valid (ifu_i1_valid),
    .ifu_i1_pc    (ifu_i1_pc),
    .ifu_i1_inst  (ifu_i1_inst)
  );

  always #5 clk = ~clk;

  // Instruction word in slot k of a packet: {pc[15:0] of packet base, k}.
  function automatic logic [31:0] inst_at(input logic [63:0] pc);
    logic [63:0] base;
    base = {pc[63:4], 4'h0};
    return {base[15:0], 14'h0, pc[3:2]};
  endfunction

  function automatic logic [127:0] mk_data(input logic [63:0] base);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = {base[15:0], 16'(k)};
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic v0, input logic [63:0] pc0,
                           input logic v1, input logic [63:0] pc1);
    chk({tag, ".i0_valid"}, 64'(ifu_i0_valid), 64'(v0));
    chk({tag, ".i0_pc"},    ifu_i0_pc, v0 ? pc0 : 64'h0);
    chk({tag, ".i0_inst"},  64'(ifu_i0_inst), v0 ? 64'(inst_at(pc0)) : 64'h0);
    chk({tag, ".i1_valid"}, 64'(ifu_i1_valid), 64'(v1));
    chk({tag, ".i1_pc"},    ifu_i1_pc, v1 ? pc1 : 64'h0);
    chk({tag, ".i1_inst"},  64'(ifu_i1_inst), v1 ? 64'(inst_at(pc1)) : 64'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] pc, input logic [1:0] s, input logic [1:0] e);
    ic_pkt_valid = 1'b1;
    ic_pkt_pc    = pc;
    ic_pkt_data  = mk_data(pc);
    ic_pkt_start = s;
    ic_pkt_end   = e;
    step();
    ic_pkt_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    ifu_flush    = 1'b0;
    ic_pkt_valid = 1'b0;
    ic_pkt_pc    = '0;
    ic_pkt_data  = '0;
    ic_pkt_start = '0;
    ic_pkt_end   = '0;
    deu_ib2_val  = 1'b0;
    deu_ib3_val  = 1'b0;
    #12;
    chk("reset.ready", 64'(ic_pkt_ready), 64'h1);
    chk_issue("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Full packet, dual issue, then pop.
    step();
    ic_pkt_valid = 1'b1;
    ic_pkt_pc    = 64'h1000;
    ic_pkt_data  = mk_data(64'h1000);
    ic_pkt_start = 2'd0;
    ic_pkt_end   = 2'd3;
    #1 chk_issue("nobypass", 0, 0, 0, 0);
    step();
    ic_pkt_valid = 1'b0;
    #1 chk_issue("p1.c1", 1, 64'h1000, 1, 64'h1004);
    step(); chk_issue("p1.c2", 1, 64'h1008, 1, 64'h100C);
    step(); chk_issue("p1.empty", 0, 0, 0, 0);
    chk("p1.ready", 64'(ic_pkt_ready), 64'h1);

    // Budget 1: single issue only.
    deu_ib2_val = 1'b1;
    send(64'h2000, 2'd1, 2'd2);
    #1 chk_issue("b1.c1", 1, 64'h2004, 0, 0);
    step(); chk_issue("b1.c2", 1, 64'h2008, 0, 0);
    step(); chk_issue("b1.empty", 0, 0, 0, 0);
    deu_ib2_val = 1'b0;

    // Budget 0 stall with a full queue, then resume.
    deu_ib3_val = 1'b1;
    send(64'h2000, 2'd1, 2'd2);
    send(64'h5000, 2'd0, 2'd1);
    #1 chk("stall.ready", 64'(ic_pkt_ready), 64'h0);
    chk_issue("stall.c1", 0, 0, 0, 0);
    step(); chk_issue("stall.c2", 0, 0, 0, 0);
    step(); chk_issue("stall.c3", 0, 0, 0, 0);
    deu_ib3_val = 1'b0;
    #1 chk_issue("resume.c1", 1, 64'h2004, 1, 64'h2008);
    step(); chk_issue("resume.c2", 1, 64'h5000, 1, 64'h5004);
    step(); chk_issue("resume.empty", 0, 0, 0, 0);
    chk("resume.ready", 64'(ic_pkt_ready), 64'h1);

    // Single remaining slot in head with a second packet queued.
    deu_ib3_val = 1'b1;
    send(64'h3000, 2'd3, 2'd3);
    send(64'h4000, 2'd0, 2'd1);
    deu_ib3_val = 1'b0;
`ifdef IFU_CROSS_PKT_PAIR_EN
    #1 chk_issue("xpkt.c1", 1, 64'h300C, 1, 64'h4000);
    step(); chk_issue("xpkt.c2", 1, 64'h4004, 0, 0);
`else
    #1 chk_issue("xpkt.c1", 1, 64'h300C, 0, 0);
    step(); chk_issue("xpkt.c2", 1, 64'h4000, 1, 64'h4004);
`endif
    step(); chk_issue("xpkt.empty", 0, 0, 0, 0);

    // Flush with a full queue and an incoming packet.
    deu_ib3_val = 1'b1;
    send(64'h7000, 2'd0, 2'd3);
    send(64'h8000, 2'd0, 2'd3);
    #1 chk("flush.full", 64'(ic_pkt_ready), 64'h0);
    deu_ib3_val  = 1'b0;
    ifu_flush    = 1'b1;
    ic_pkt_valid = 1'b1;
    ic_pkt_pc    = 64'h9000;
    ic_pkt_data  = mk_data(64'h9000);
    ic_pkt_start = 2'd0;
    ic_pkt_end   = 2'd3;
    #1 chk_issue("flush.cyc", 0, 0, 0, 0);
    step();
    ifu_flush    = 1'b0;
    ic_pkt_valid = 1'b0;
    #1 chk("flush.ready", 64'(ic_pkt_ready), 64'h1);
    chk_issue("flush.after", 0, 0, 0, 0);
    step(); chk_issue("flush.after2", 0, 0, 0, 0);

    // Inverted range is dropped; queue stays usable.
    send(64'hA000, 2'd2, 2'd1);
    #1 chk_issue("inv.none", 0, 0, 0, 0);
    chk("inv.ready", 64'(ic_pkt_ready), 64'h1);
    send(64'h6000, 2'd0, 2'd3);
    #1 chk_issue("inv.next", 1, 64'h6000, 1, 64'h6004);

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1 chk_issue("arst", 0, 0, 0, 0);
    chk("arst.ready", 64'(ic_pkt_ready), 64'h1);
    step();
    rst_n = 1'b1;
    step(); chk_issue("arst.after", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
